// File: rtl/reset_seq_gen.sv
// Reset sequencer: holds N_CH reset channels asserted, then releases them one by one.
// Latency: rst_o[i] falls INIT_DLY + i*STAGE_DLY cycles after start; rst_done after N_CH stages.
// Backpressure: hold stalls the ASSERT->RELEASE step; soft_req restarts; all outputs registered.
module reset_seq_gen #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int INIT_DLY  = 1000,
  parameter int STAGE_DLY = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            soft_req,
  input  logic            hold,
  output logic [N_CH-1:0] rst_o,
  output logic            rst_done,
  output logic [7:0]      seq_count
);

  // idx counts released channels, so it must reach N_CH itself
  localparam int IDX_W = $clog2(N_CH + 1);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_DLY - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_ALL    = IDX_W'(N_CH);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [N_CH-1:0]   r_rst_o;
  logic              r_done;
  logic [7:0]        r_seq;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_seq_inc;
  logic [N_CH-1:0]   w_rst_o_nxt;
  logic              w_done_nxt;
  logic [7:0]        w_seq_nxt;

  // State and output registers; reset clears everything including the sequence counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_o <= '1;
      r_done  <= 1'b0;
      r_seq   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst_o <= w_rst_o_nxt;
      r_done  <= w_done_nxt;
      r_seq   <= w_seq_nxt;
    end
  end

  // Next-state logic: soft_req restarts from ASSERT, otherwise walk the release stages
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_seq_inc   = 1'b0;
    if (soft_req) begin
      w_state_nxt = S_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_ASSERT: begin
          if (r_cnt == INIT_LAST) begin
            // counter saturates here while hold is high
            if (!hold) begin
              w_state_nxt = S_RELEASE;
              w_cnt_nxt   = '0;
              w_idx_nxt   = IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (r_cnt == STAGE_LAST) begin
            w_cnt_nxt = '0;
            if (r_idx < IDX_ALL) begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end else begin
              w_state_nxt = S_DONE;
              w_seq_inc   = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_ASSERT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: channels below the release index are free, giving a contiguous low-order run
  always_comb begin
    w_rst_o_nxt = '1;
    for (int i = 0; i < N_CH; i++) begin
      w_rst_o_nxt[i] = (IDX_W'(i) >= w_idx_nxt);
    end
    w_done_nxt = (w_state_nxt == S_DONE);
    w_seq_nxt  = r_seq + {7'd0, w_seq_inc};
  end

  assign rst_o     = r_rst_o;
  assign rst_done  = r_done;
  assign seq_count = r_seq;

endmodule
